// File: rtl/ysyx_22050612_ifu_pkg.sv
// ysyx_22050612 fetch unit shared definitions
// state encoding, reset PC and NOP word
package ysyx_22050612_ifu_pkg;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_STALL = 3'd4;

endpackage

// File: rtl/ysyx_22050612_ifu_pc.sv
// ysyx_22050612 fetch PC register
// redirect has priority over sequential +4 advance
module ysyx_22050612_ifu_pc
  import ysyx_22050612_ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redir,
  input  logic [63:0] i_redir_pc,
  input  logic        i_inc,
  output logic [63:0] o_pc,
  output logic [63:0] o_pc_nxt
);

  logic [63:0] r_pc;

  // next-PC select: redirect, +4 (wraps mod 2^64), or hold
  always_comb begin
    o_pc_nxt = r_pc;
    if (i_redir)
      o_pc_nxt = i_redir_pc;
    else if (i_inc)
      o_pc_nxt = r_pc + 64'd4;
  end

  // PC state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pc <= RESET_PC;
    else
      r_pc <= o_pc_nxt;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// ysyx_22050612 instruction fetch unit
// one outstanding fetch, registered decode output
module ysyx_22050612_ifu
  import ysyx_22050612_ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        fetch_fault
);

  logic [2:0]  r_state;
  logic        r_drop;
  logic        r_req_valid;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [63:0] r_inst_pc;
  logic        r_fault;

  logic [2:0]  w_state_nxt;
  logic        w_drop_nxt;
  logic        w_inc;
  logic        w_load;
  logic        w_load_flt;
  logic        w_redir;
  logic        w_hs;
  logic [63:0] w_pc;
  logic [63:0] w_pc_nxt;

  assign w_redir = redirect_valid && (r_state != S_BOOT);
  assign w_hs    = r_req_valid && imem_req_ready;

  ysyx_22050612_ifu_pc u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_redir    (w_redir),
    .i_redir_pc (redirect_pc),
    .i_inc      (w_inc),
    .o_pc       (w_pc),
    .o_pc_nxt   (w_pc_nxt)
  );

  // fetch FSM next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_inc       = 1'b0;
    w_load      = 1'b0;
    w_load_flt  = 1'b0;
    case (r_state)
      S_BOOT: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_redir) begin
          w_state_nxt = w_hs ? S_WAIT : S_REQ;
          w_drop_nxt  = w_hs;
        end else if (w_pc[1:0] != 2'b00) begin
          w_load      = 1'b1;
          w_load_flt  = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (w_hs) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (w_redir || r_drop) begin
            w_state_nxt = S_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_load      = 1'b1;
            w_load_flt  = imem_rsp_err;
            w_state_nxt = S_HOLD;
          end
        end else if (w_redir) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redir) begin
          w_state_nxt = S_REQ;
        end else if (inst_ready) begin
          if (r_fault) begin
            w_state_nxt = S_STALL;
          end else begin
            w_inc       = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_STALL: if (w_redir) w_state_nxt = S_REQ;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // FSM state, drop flag and registered request valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_BOOT;
      r_drop      <= 1'b0;
      r_req_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drop      <= w_drop_nxt;
      r_req_valid <= (w_state_nxt == S_REQ) &&
                     (w_pc_nxt[1:0] == 2'b00);
    end
  end

  // decode-facing output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_valid <= 1'b0;
      r_inst       <= NOP;
      r_inst_pc    <= RESET_PC;
      r_fault      <= 1'b0;
    end else begin
      r_inst_valid <= (w_state_nxt == S_HOLD);
      if (w_load) begin
        r_inst    <= w_load_flt ? NOP : imem_rsp_data;
        r_inst_pc <= w_pc;
        r_fault   <= w_load_flt;
      end
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = w_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fetch_fault    = r_fault;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// ysyx_22050612 fetch unit bench
// directed fetch, stall, redirect and fault sequences
module tb_ysyx_22050612_ifu;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        fetch_fault;

  int n_tests;
  int n_fail;

  ysyx_22050612_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, ".req_addr"}, imem_req_addr, 64'h8000_0000);
    chk({tag, ".inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, ".inst"}, 64'(inst), 64'h13);
    chk({tag, ".inst_pc"}, inst_pc, 64'h8000_0000);
    chk({tag, ".fault"}, 64'(fetch_fault), 64'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    step();
    step();
    chk_reset("rst");

    // release: BOOT for one cycle, then request
    rst_n = 1'b1;
    step();
    chk("boot.req_valid", 64'(imem_req_valid), 64'd1);
    chk("boot.req_addr", imem_req_addr, 64'h8000_0000);

    // zero-wait fetch of 0x00000297
    imem_req_ready = 1'b1;
    step();
    chk("wait.req_valid", 64'(imem_req_valid), 64'd0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0297;
    step();
    imem_rsp_valid = 1'b0;
    chk("f0.inst_valid", 64'(inst_valid), 64'd1);
    chk("f0.inst", 64'(inst), 64'h297);
    chk("f0.inst_pc", inst_pc, 64'h8000_0000);
    chk("f0.fault", 64'(fetch_fault), 64'd0);

    // decode back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold.inst_valid", 64'(inst_valid), 64'd1);
      chk("hold.inst", 64'(inst), 64'h297);
      chk("hold.inst_pc", inst_pc, 64'h8000_0000);
      chk("hold.req_valid", 64'(imem_req_valid), 64'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("f1.req_valid", 64'(imem_req_valid), 64'd1);
    chk("f1.req_addr", imem_req_addr, 64'h8000_0004);
    chk("f1.inst_valid", 64'(inst_valid), 64'd0);

    // redirect while waiting: old response dropped
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    chk("rw.req_valid", 64'(imem_req_valid), 64'd0);
    chk("rw.req_addr", imem_req_addr, 64'h8000_0100);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("rw.drop_valid", 64'(inst_valid), 64'd0);
    chk("rw.req_valid2", 64'(imem_req_valid), 64'd1);
    chk("rw.req_addr2", imem_req_addr, 64'h8000_0100);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    step();
    imem_rsp_valid = 1'b0;
    chk("rw.inst", 64'(inst), 64'h0010_0093);
    chk("rw.inst_pc", inst_pc, 64'h8000_0100);

    // redirect coinciding with decode handshake
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    step();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    chk("rh.inst_valid", 64'(inst_valid), 64'd0);
    chk("rh.req_valid", 64'(imem_req_valid), 64'd1);
    chk("rh.req_addr", imem_req_addr, 64'h8000_0200);

    // misaligned redirect: fault marker, then stall
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    step();
    redirect_valid = 1'b0;
    chk("mis.req_valid", 64'(imem_req_valid), 64'd0);
    step();
    chk("mis.inst_valid", 64'(inst_valid), 64'd1);
    chk("mis.fault", 64'(fetch_fault), 64'd1);
    chk("mis.inst", 64'(inst), 64'h13);
    chk("mis.inst_pc", inst_pc, 64'h8000_0102);
    chk("mis.req_valid2", 64'(imem_req_valid), 64'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall.inst_valid", 64'(inst_valid), 64'd0);
      chk("stall.req_valid", 64'(imem_req_valid), 64'd0);
      step();
    end

    // PC wrap at top of address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap.req_valid", 64'(imem_req_valid), 64'd1);
    chk("wrap.req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0;
    chk("wrap.inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("wrap.next_valid", 64'(imem_req_valid), 64'd1);
    chk("wrap.next_addr", imem_req_addr, 64'd0);

    // access fault response
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    imem_rsp_err   = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk("err.inst_valid", 64'(inst_valid), 64'd1);
    chk("err.fault", 64'(fetch_fault), 64'd1);
    chk("err.inst", 64'(inst), 64'h13);
    chk("err.inst_pc", inst_pc, 64'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("err.stall_valid", 64'(inst_valid), 64'd0);
    chk("err.stall_req", 64'(imem_req_valid), 64'd0);

    // reset in the middle of a transaction
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0400;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("mrst");
    step();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    step();
    imem_rsp_valid = 1'b0;
    chk("mrst.inst_valid", 64'(inst_valid), 64'd0);
    chk("mrst.req_valid", 64'(imem_req_valid), 64'd1);
    chk("mrst.req_addr", imem_req_addr, 64'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_ifu.md
# ysyx_22050612_ifu

Instruction fetch unit for the single-issue RV64 core: holds the PC, issues one 32-bit instruction fetch at a time to instruction memory over a valid/ready request channel, and presents each fetched word with its PC to the decode stage over a valid/ready channel. It sits directly upstream of the decoder and directly downstream of the branch/jump resolution logic, which steers it through a redirect port.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, PC of the first fetch after reset.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- redirect_valid  in  1  next fetch PC is overridden this cycle.
- redirect_pc  in  64  redirect target.
- imem_req_valid  out  1  fetch request pending.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  64  fetch address.
- imem_rsp_valid  in  1  response present (one cycle, exactly one per accepted request).
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  access fault on this response.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  instruction word to decode.
- inst_pc  out  64  PC of `inst`.
- fetch_fault  out  1  `inst` is a fault marker, not a real instruction.

## Operation
- States: BOOT, REQ, WAIT, HOLD, STALL. Reset -> BOOT, pc=RESET_PC.
- BOOT: one cycle, -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On req handshake -> WAIT. If pc[1:0]!=0, no request is issued: load fault marker (inst=32'h00000013, fetch_fault=1, inst_pc=pc) -> HOLD.
- WAIT: on imem_rsp_valid capture {data, err, pc} into output register -> HOLD; fetch_fault=imem_rsp_err; on err, inst=32'h00000013.
- HOLD: inst_valid=1, outputs stable. On inst_ready: non-fault -> pc=pc+4 (mod 2^64) -> REQ; fault -> STALL.
- STALL: no requests, inst_valid=0, until redirect.
- Redirect (any state except BOOT): pc=redirect_pc, next state REQ.
  - REQ: imem_req_addr switches to redirect_pc next cycle; a request handshaken in the same cycle as redirect is treated as accepted -> WAIT with drop flag set.
  - WAIT: set drop flag; matching response is discarded, then -> REQ. If the response arrives in the redirect cycle it is discarded directly.
  - HOLD: inst_valid drops next cycle. If inst_ready is also high, the transfer counts as completed; next pc is redirect_pc, not pc+4.
  - STALL: -> REQ.
- Only one request outstanding at any time; drop flag clears on the discarded response.
- Redirect during BOOT ignored.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=32'h00000013, inst_pc=RESET_PC, fetch_fault=0.
- rst_n release at edge 0 -> imem_req_valid=1 after edge 1.
- Response at cycle t -> inst_valid=1 at t+1 (registered).
- Consume at cycle t -> next imem_req_valid=1 at t+1; zero-wait memory gives one instruction per 3 cycles.
- Redirect at cycle t -> imem_req_addr=redirect_pc from t+1.
- rst_n assertion mid-transaction: immediate return to reset values; any later stale response is ignored (BOOT/REQ do not sample rsp).
- Outputs driven only from registers.

## Structure
- Shared package: state encoding constants, RESET_PC default, NOP constant 32'h00000013.
- Natural sub-module: ysyx_22050612_ifu_pc (PC register with reset value, +4 incrementer, redirect mux); FSM and output register in the top.

## Test plan
- Reset release, zero-wait memory returning 32'h00000297 -> request at 64'h80000000, inst_valid with inst_pc=64'h80000000 one cycle after rsp, next request at 64'h80000004.
- inst_ready held low 5 cycles in HOLD -> inst/inst_pc stable, no new request issued.
- Redirect to 64'h80000100 while WAIT -> old response discarded, next inst_pc=64'h80000100.
- Redirect to 64'h80000200 in same cycle as inst handshake -> instruction counted once, next request address 64'h80000200.
- Redirect to 64'h80000102 -> no memory request, fetch_fault=1, inst=32'h00000013; after consume, STALL until next redirect.
- pc=64'hFFFFFFFF_FFFFFFFC consumed -> next request at 64'h0; imem_rsp_err=1 -> fetch_fault=1, then STALL.
